avg_sram_reader: RTL and testbench
==================================

# avg_sram_reader

Raster-scan read-out engine for the per-pixel running-average map that the averaging writer stores in SRAM. It shares the SRAM port with the writer through a request/grant pair and fetches every pixel word of a frame. Each word is rebuilt into the 18-bit sum and streamed to downstream consumers (display path, detection logic) over a valid/ready interface. A 2-entry output FIFO keeps SRAM reads running while the consumer stalls.

## Interface
- COLS, default `PIXEL_COLUMN (640): pixels per row; px range 0..COLS-1.
- ROWS, default `PIXEL_ROW (480): rows per frame; py range 0..ROWS-1.
- FIFO_DEPTH, default 2: output buffer entries; fixed at 2, no other value supported.
- i_50M_clk  in  1  clock; every flop is rising-edge.
- i_rst  in  1  reset, asynchronous, active-high; clock i_50M_clk.
- i_start  in  1  one-cycle pulse that starts a frame scan; ignored unless in S_IDLE.
- i_stop  in  1  level; aborts the scan and flushes the FIFO.
- o_sram_req  out  1  read request to the SRAM arbiter.
- i_sram_gnt  in  1  grant; a read is accepted in a cycle where o_sram_req && i_sram_gnt.
- o_sram_addr  out  20  read address = 640*px + py, the same mapping the writer uses.
- i_sram_data  in  16  read word, valid the cycle after acceptance.
- o_valid  out  1  output sample valid.
- i_ready  in  1  consumer ready; a transfer occurs when o_valid && i_ready.
- o_data  out  18  {word, 2'b00}, the rebuilt sum.
- o_px  out  $clog2(COLS)  column of o_data.
- o_py  out  $clog2(ROWS)  row of o_data.
- o_last  out  1  high with the final pixel (COLS-1, ROWS-1).
- o_busy  out  1  high in any state other than S_IDLE.

## Operation
- Scan order: px increments fastest, then py; one read per pixel; COLS*ROWS reads per frame.
- State S_IDLE: outputs quiet. i_start moves to S_SCAN with px = py = 0.
- State S_SCAN: o_sram_req = (fifo_count + inflight < 2). After an accepted read, px/py advance. After the accepted read of (COLS-1, ROWS-1), move to S_DRAIN.
- State S_DRAIN: o_sram_req = 0. Return to S_IDLE once the FIFO is empty and nothing is in flight.
- i_stop in any state: the next state is S_IDLE, the FIFO is cleared, the in-flight flag is dropped, and the returning word is discarded. i_stop has priority over i_start.
- inflight is a 1-bit flag. It sets on acceptance and clears on the return cycle.
- FIFO push and pop in the same cycle: the count is unchanged and order is preserved.
- The FIFO never overflows because of the credit rule. There is no data-dependent behaviour.
- i_start while busy: ignored.

## Timing
- Reset values: state S_IDLE, o_sram_req 0, o_valid 0, o_data 0, o_px 0, o_py 0, o_last 0, o_busy 0, FIFO empty, inflight 0.
- o_sram_addr is combinational from the registered px/py.
- Cycle-level sequence with i_ready and i_sram_gnt held high: i_start at T0, req at T1, data returns at T2 and is pushed, o_valid at T3.
- Throughput with i_ready and i_sram_gnt held high: one pixel per 2 cycles, because inflight stalls back-to-back reads.
- When o_valid is high, o_data, o_px, o_py and o_last hold stable until the transfer occurs.

## Configuration
- AVG_READER_THRESH_EN defined:
  - Adds input i_thresh[17:0].
  - Adds output o_motion, registered in the FIFO alongside the data.
  - o_motion = (o_data > i_thresh), unsigned compare, sampled at push.
- AVG_READER_THRESH_EN undefined: no port, no comparator, no extra FIFO bit.

## Structure
- Shared package avg_pkg holds:
  - The state enum (S_IDLE, S_SCAN, S_DRAIN).
  - The address function addr(px, py) = 640*px + py, also used by the writer.
  - The width constants for the data word and the SRAM address.
- Sub-module avg_out_fifo: a 2-entry synchronous FIFO with push, pop, flush, count and a registered head.

## Test plan
- Reset during S_SCAN with o_valid high: all outputs return to reset values at once; i_start afterwards begins at px = py = 0.
- Full frame with ready and grant held high: COLS*ROWS transfers in raster order. The first beat is px = 0, py = 0, addr 0. The beat at px = 1, py = 0 has addr 640. Exactly one o_last, on (COLS-1, ROWS-1). o_busy falls after the last transfer.
- SRAM returns 16'hFFFF: o_data = 18'h3FFFC. SRAM returns 16'h0001: o_data = 18'h00004.
- i_ready held low for 20 cycles: exactly two reads accepted, o_sram_req low thereafter. Releasing ready delivers the buffered pixels in order with no loss.
- i_sram_gnt low for 5 cycles mid-scan: o_sram_addr is held and px/py do not advance. The scan resumes on grant.
- i_stop for 1 cycle while a read is in flight: the return word is discarded, o_valid is 0 the next cycle, and the block is in S_IDLE.
- With AVG_READER_THRESH_EN defined, i_thresh = 18'h00100:
  - Word 16'h0041 gives o_motion 1.
  - Word 16'h0040 gives o_motion 0.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared types and helpers for the running-average SRAM writer and reader.
package avg_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SUM_W  = 18;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned PX_W   = 10;
  localparam int unsigned PY_W   = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Pixel-to-word mapping shared with the writer: 640*px + py.
  function automatic logic [ADDR_W-1:0] addr(input logic [PX_W-1:0] px,
                                             input logic [PY_W-1:0] py);
    logic [ADDR_W-1:0] px_w;
    px_w = ADDR_W'(px);
    return (px_w << 9) + (px_w << 7) + ADDR_W'(py);
  endfunction

endpackage

// File: rtl/avg_out_fifo.sv
// Two-entry synchronous FIFO with a registered head word, flush, and the
// next-cycle occupancy exposed so the reader can register its request.
module avg_out_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         i_50M_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count_next_c,
  output logic         o_valid,
  output logic [W-1:0] o_head
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         valid_q;
  logic         pop_ok;

  assign pop_ok = i_pop && (count_q != 2'd0);

  // Head is always entry 0; a simultaneous push/pop keeps arrival order.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      count_d = 2'd0;
    end else begin
      case ({i_push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) head_d = i_din;
          else                 tail_d = i_din;
          count_d = 2'(count_q + 2'd1);
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = 2'(count_q - 2'd1);
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = i_din;
          end else begin
            head_d = tail_q;
            tail_d = i_din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_50M_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= (count_d != 2'd0);
    end
  end

  assign o_count_next_c = count_d;
  assign o_valid        = valid_q;
  assign o_head         = head_q;

endmodule

// File: rtl/avg_sram_reader.sv
// Raster-scan reader of the running-average map; streams rebuilt 18-bit sums.
// Optional AVG_READER_THRESH_EN adds i_thresh and a per-pixel o_motion flag.
`ifndef PIXEL_COLUMN
`define PIXEL_COLUMN 640
`endif
`ifndef PIXEL_ROW
`define PIXEL_ROW 480
`endif

module avg_sram_reader
  import avg_pkg::*;
#(
  parameter int unsigned COLS       = `PIXEL_COLUMN,
  parameter int unsigned ROWS       = `PIXEL_ROW,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned PXO_W     = $clog2(COLS),
  localparam int unsigned PYO_W     = $clog2(ROWS)
) (
  input  logic              i_50M_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_sram_req,
  input  logic              i_sram_gnt,
  output logic [19:0]       o_sram_addr,
  input  logic [15:0]       i_sram_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [17:0]       o_data,
  output logic [PXO_W-1:0]  o_px,
  output logic [PYO_W-1:0]  o_py,
  output logic              o_last,
`ifdef AVG_READER_THRESH_EN
  input  logic [17:0]       i_thresh,
  output logic              o_motion,
`endif
  output logic              o_busy
);

  localparam int unsigned PAY_W = SUM_W + PXO_W + PYO_W + 1
`ifdef AVG_READER_THRESH_EN
                                  + 1
`endif
                                  ;

  state_e             state_q, state_d;
  logic [PXO_W-1:0]   px_q, px_d, rd_px_q, rd_px_d;
  logic [PYO_W-1:0]   py_q, py_d, rd_py_q, rd_py_d;
  logic               rd_last_q, rd_last_d;
  logic               inflight_q, inflight_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;

  logic               acc, push, pop, at_end, fifo_valid;
  logic [1:0]         count_next;
  logic [SUM_W-1:0]   sum_c;
  logic [PAY_W-1:0]   push_word, head;

  assign acc    = req_q && i_sram_gnt && !i_stop;
  assign push   = inflight_q && !i_stop;
  assign pop    = fifo_valid && i_ready;
  assign at_end = (px_q == PXO_W'(COLS - 1)) && (py_q == PYO_W'(ROWS - 1));
  assign sum_c  = {i_sram_data, 2'b00};

  // Scan sequencing, read tracking and credit-based request generation.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    rd_px_d    = rd_px_q;
    rd_py_d    = rd_py_q;
    rd_last_d  = rd_last_q;
    inflight_d = acc;
    if (acc) begin
      rd_px_d   = px_q;
      rd_py_d   = py_q;
      rd_last_d = at_end;
    end
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SCAN;
          px_d    = '0;
          py_d    = '0;
        end
      end
      S_SCAN: begin
        if (acc) begin
          if (at_end) begin
            state_d = S_DRAIN;
          end else if (px_q == PXO_W'(COLS - 1)) begin
            px_d = '0;
            py_d = PYO_W'(py_q + 1'b1);
          end else begin
            px_d = PXO_W'(px_q + 1'b1);
          end
        end
      end
      S_DRAIN: begin
        if ((count_next == 2'd0) && !inflight_d) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_stop) begin
      state_d    = S_IDLE;
      inflight_d = 1'b0;
    end
    // One read outstanding at a time, and never more than the FIFO can hold.
    req_d  = (state_d == S_SCAN) && !inflight_d &&
             ((3'(count_next) + 3'(inflight_d)) < 3'(FIFO_DEPTH));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_50M_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      px_q       <= '0;
      py_q       <= '0;
      rd_px_q    <= '0;
      rd_py_q    <= '0;
      rd_last_q  <= 1'b0;
      inflight_q <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      rd_px_q    <= rd_px_d;
      rd_py_q    <= rd_py_d;
      rd_last_q  <= rd_last_d;
      inflight_q <= inflight_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
    end
  end

`ifdef AVG_READER_THRESH_EN
  assign push_word = {sum_c, rd_px_q, rd_py_q, rd_last_q, (sum_c > i_thresh)};
  assign {o_data, o_px, o_py, o_last, o_motion} = head;
`else
  assign push_word = {sum_c, rd_px_q, rd_py_q, rd_last_q};
  assign {o_data, o_px, o_py, o_last} = head;
`endif

  avg_out_fifo #(.W(PAY_W)) u_fifo (
    .i_50M_clk      (i_50M_clk),
    .i_rst          (i_rst),
    .i_push         (push),
    .i_din          (push_word),
    .i_pop          (pop),
    .i_flush        (i_stop),
    .o_count_next_c (count_next),
    .o_valid        (fifo_valid),
    .o_head         (head)
  );

  assign o_sram_addr = addr(PX_W'(px_q), PY_W'(py_q));
  assign o_sram_req  = req_q;
  assign o_valid     = fifo_valid;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_avg_sram_reader.sv
// Self-checking bench for avg_sram_reader on a small 8x4 frame against a
// queue-based reference model of the scan, SRAM return path and output buffer.
module tb_avg_sram_reader;

  localparam int unsigned COLS = 8;
  localparam int unsigned ROWS = 4;
  localparam int unsigned N    = COLS * ROWS;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_stop, i_sram_gnt, i_ready;
  logic [15:0] i_sram_data;
  logic        o_sram_req, o_valid, o_last, o_busy;
  logic [19:0] o_sram_addr;
  logic [17:0] o_data;
  logic [2:0]  o_px;
  logic [1:0]  o_py;
`ifdef AVG_READER_THRESH_EN
  logic [17:0] i_thresh = 18'h00100;
  logic        o_motion;
`endif

  always #5 clk = ~clk;

  avg_sram_reader #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_50M_clk   (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .o_sram_req  (o_sram_req),
    .i_sram_gnt  (i_sram_gnt),
    .o_sram_addr (o_sram_addr),
    .i_sram_data (i_sram_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_px        (o_px),
    .o_py        (o_py),
    .o_last      (o_last),
`ifdef AVG_READER_THRESH_EN
    .i_thresh    (i_thresh),
    .o_motion    (o_motion),
`endif
    .o_busy      (o_busy)
  );

  typedef struct {
    logic [17:0] data;
    int          px;
    int          py;
    logic        last;
    logic        motion;
  } beat_t;

  beat_t       q[$];
  beat_t       pend;
  logic [15:0] ovr[$];
  bit          scanning, pending;
  int          idx;
  int          checks = 0, errors = 0;
  int          xfers, lasts, accepts;
  logic [17:0] seen00, seen10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input int k);
    return 32'(640 * (k % COLS) + k / COLS);
  endfunction

  // One clock cycle: handshakes judged before the edge, model advanced,
  // then registered outputs compared one time unit after the edge.
  task automatic tick();
    bit          acc, xfer, idle_before, new_pend;
    beat_t       b;
    logic [15:0] w;
    idle_before = !(scanning || pending || q.size() > 0);
    acc  = o_sram_req && i_sram_gnt && !i_stop;
    xfer = o_valid && i_ready;
    if (scanning) chk("addr", 32'(o_sram_addr), exp_addr(idx));
    if (xfer) begin
      if (q.size() == 0) begin
        chk("xfer_empty", 32'(o_valid), 32'd0);
      end else begin
        b = q.pop_front();
        chk("data", 32'(o_data), 32'(b.data));
        chk("px", 32'(o_px), 32'(b.px));
        chk("py", 32'(o_py), 32'(b.py));
        chk("last", 32'(o_last), 32'(b.last));
`ifdef AVG_READER_THRESH_EN
        chk("motion", 32'(o_motion), 32'(b.motion));
`endif
        if (b.px == 0 && b.py == 0) seen00 = o_data;
        if (b.px == 1 && b.py == 0) seen10 = o_data;
        xfers++;
        if (o_last) lasts++;
      end
    end
    if (pending && !i_stop) q.push_back(pend);
    new_pend = 1'b0;
    if (acc && scanning) begin
      accepts++;
      w = (ovr.size() > 0) ? ovr.pop_front() : 16'($urandom);
      pend.data   = {w, 2'b00};
      pend.px     = idx % COLS;
      pend.py     = idx / COLS;
      pend.last   = (idx == N - 1);
`ifdef AVG_READER_THRESH_EN
      pend.motion = ({w, 2'b00} > i_thresh);
`else
      pend.motion = 1'b0;
`endif
      idx++;
      if (idx == N) scanning = 1'b0;
      new_pend = 1'b1;
    end
    if (i_stop) begin
      q.delete();
      scanning = 1'b0;
      new_pend = 1'b0;
    end else if (i_start && idle_before) begin
      scanning = 1'b1;
      idx      = 0;
    end
    pending = new_pend;
    @(posedge clk);
    #1;
    i_sram_data = pending ? pend.data[17:2] : 16'($urandom);
    chk("valid", 32'(o_valid), 32'(q.size() > 0));
    chk("req", 32'(o_sram_req), 32'(scanning && !pending && q.size() < 2));
    chk("busy", 32'(o_busy), 32'(scanning || pending || q.size() > 0));
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_frame(input bit rnd_gnt, input bit rnd_rdy, input int budget);
    int n = 0;
    while ((scanning || pending || q.size() > 0) && n < budget) begin
      if (rnd_gnt) i_sram_gnt = ($urandom_range(0, 3) != 0);
      if (rnd_rdy) i_ready    = ($urandom_range(0, 2) != 0);
      if (n == 7) i_start = 1'b1;
      tick();
      i_start = 1'b0;
      n++;
    end
    chk("frame_done_busy", 32'(o_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(o_sram_req), 32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_data"}, 32'(o_data), 32'd0);
    chk({tag, "_px"}, 32'(o_px), 32'd0);
    chk({tag, "_py"}, 32'(o_py), 32'd0);
    chk({tag, "_last"}, 32'(o_last), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [19:0] held;
    int          n;
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_sram_gnt = 1'b0; i_ready = 1'b0; i_sram_data = 16'h0;
    scanning = 1'b0; pending = 1'b0; idx = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    i_rst = 1'b0;

    // Full frame, grant and ready held high, with boundary data words.
    i_sram_gnt = 1'b1; i_ready = 1'b1;
    ovr.push_back(16'hFFFF);
    ovr.push_back(16'h0001);
`ifdef AVG_READER_THRESH_EN
    ovr.push_back(16'h0041);
    ovr.push_back(16'h0040);
`endif
    xfers = 0; lasts = 0;
    pulse_start();
    run_frame(1'b0, 1'b0, 200);
    chk("full_xfers", 32'(xfers), 32'(N));
    chk("full_lasts", 32'(lasts), 32'd1);
    chk("word_ffff", 32'(seen00), 32'h3FFFC);
    chk("word_0001", 32'(seen10), 32'h00004);

    // Consumer stalled: only two reads may be taken.
    i_ready = 1'b0; accepts = 0;
    pulse_start();
    repeat (20) tick();
    chk("stall_accepts", 32'(accepts), 32'd2);
    chk("stall_req", 32'(o_sram_req), 32'd0);
    i_ready = 1'b1;
    repeat (6) tick();
    // Grant withheld mid-scan: address must hold.
    i_sram_gnt = 1'b0;
    tick();
    held = o_sram_addr;
    repeat (5) tick();
    chk("gnt_hold_addr", 32'(o_sram_addr), 32'(held));
    i_sram_gnt = 1'b1;
    xfers = 0; lasts = 0;
    run_frame(1'b0, 1'b0, 200);
    chk("stall_lasts", 32'(lasts), 32'd1);

    // Randomized grant/ready frames, including a start pulse while busy.
    for (int f = 0; f < 3; f++) begin
      xfers = 0; lasts = 0;
      pulse_start();
      run_frame(1'b1, 1'b1, 2000);
      chk("rand_xfers", 32'(xfers), 32'(N));
      chk("rand_lasts", 32'(lasts), 32'd1);
    end

    // Stop while a read is in flight.
    i_sram_gnt = 1'b1; i_ready = 1'b1;
    pulse_start();
    n = 0;
    while (!pending && n < 20) begin tick(); n++; end
    chk("stop_pending_seen", 32'(pending), 32'd1);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    chk("stop_valid", 32'(o_valid), 32'd0);
    chk("stop_busy", 32'(o_busy), 32'd0);
    repeat (4) tick();

    // Asynchronous reset mid-scan with data waiting at the output.
    i_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!o_valid && n < 20) begin tick(); n++; end
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    q.delete(); scanning = 1'b0; pending = 1'b0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    i_ready = 1'b1;
    xfers = 0; lasts = 0;
    pulse_start();
    chk("restart_addr", 32'(o_sram_addr), 32'd0);
    run_frame(1'b0, 1'b0, 200);
    chk("restart_xfers", 32'(xfers), 32'(N));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
